button_debouncer: RTL

Debounces and edge-detects the EGO1 push-buttons, giving the design clean inputs to pair with its LED outputs. Each raw button line goes through a 2-flop synchronizer and then its own debounce state machine. The block drives a stable level per button, plus a one-cycle press pulse and a one-cycle release pulse. It sits between the board pins and any control logic, such as the flowing-light speed, direction or pause controls.

---
 rtl/button_debouncer.sv | 91 +++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: per-button 2-flop sync + debounce FSM; clk/rst in, btn_in raw, btn_level/btn_press/btn_release registered out
module button_debouncer #(
  parameter int N_BTN = 5,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_CHK, DOWN, RELEASE_CHK} state_t;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sync1_q, sync2_q;
    logic level_q, level_d, press_q, press_d, release_q, release_d;
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        IDLE: begin
          state_d = sync2_q ? PRESS_CHK : IDLE;
          cnt_d   = '0;
        end
        PRESS_CHK: begin
          if (!sync2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = DOWN;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DOWN: begin
          state_d = sync2_q ? DOWN : RELEASE_CHK;
          cnt_d   = '0;
        end
        RELEASE_CHK: begin
          if (sync2_q) begin
            state_d = DOWN;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        sync1_q   <= btn_in[i];
        sync2_q   <= sync1_q;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end
    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end
endmodule
